// File: rtl/token_decoder_if.sv
// ---------------------------------------------------------------------------
// token_decoder_if
//
// Purpose: bundles the token_decoder start/finish handshake and its three
// SRAM connections (token read, vocab read, output write) into one bundle.
//
// Signals:
//   cs         start request towards the decoder
//   done, err  decode finished / finished with an error stop
//   tok_addr   token SRAM read address        tok_data  token SRAM dout
//   voc_addr   vocab SRAM read address        voc_data  vocab SRAM dout
//   out_addr   output SRAM address            out_data  output SRAM din
//   out_we     output SRAM write enable
//   word_count number of separators written (only with DECODER_WORD_COUNT_EN)
//
// Modports:
//   master  the decoder itself (drives addresses, write port and status)
//   slave   the surrounding system (drives cs and the SRAM read data)
//
// Build option: DECODER_WORD_COUNT_EN adds the word_count signal.
// ---------------------------------------------------------------------------
interface token_decoder_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  cs;
   logic                  done;
   logic                  err;
   logic [ADDR_WIDTH-1:0] tok_addr;
   logic [DATA_WIDTH-1:0] tok_data;
   logic [ADDR_WIDTH-1:0] voc_addr;
   logic [DATA_WIDTH-1:0] voc_data;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_we;
`ifdef DECODER_WORD_COUNT_EN
   logic [ADDR_WIDTH-1:0] word_count;

   modport master (
      input  cs, tok_data, voc_data,
      output done, err, tok_addr, voc_addr, out_addr, out_data, out_we,
      output word_count
   );

   modport slave (
      output cs, tok_data, voc_data,
      input  done, err, tok_addr, voc_addr, out_addr, out_data, out_we,
      input  word_count
   );
`else
   modport master (
      input  cs, tok_data, voc_data,
      output done, err, tok_addr, voc_addr, out_addr, out_data, out_we
   );

   modport slave (
      output cs, tok_data, voc_data,
      input  done, err, tok_addr, voc_addr, out_addr, out_data, out_we
   );
`endif
endinterface

// File: rtl/token_decoder.sv
// ---------------------------------------------------------------------------
// token_decoder
//
// Purpose: turns a zero-terminated list of token IDs back into a
// zero-delimited character stream. Each token ID is the start address of a
// zero-terminated word in the vocab SRAM. Every word is copied byte by byte
// to the output SRAM followed by a 0 separator; a final 0 marks the end of
// the stream (so the stream ends with two zeros).
//
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset; aborts any decode immediately
//   bus   token_decoder_if.master
//           cs in, done/err out (registered, held until next accepted cs)
//           tok_addr/tok_data, voc_addr/voc_data: 1-cycle-latency reads
//           out_addr/out_data/out_we: output SRAM write port
//
// Parameters: ADDR_WIDTH, DATA_WIDTH, MAX_WORD_LEN (max chars per word).
//
// Build option: DECODER_WORD_COUNT_EN adds bus.word_count, the number of
// separators written during the current/last decode.
// ---------------------------------------------------------------------------
module token_decoder #(
   parameter int ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int MAX_WORD_LEN = 15
) (
   input  logic            clk,
   input  logic            rst,
   token_decoder_if.master bus
);

   localparam int LEN_W = $clog2(MAX_WORD_LEN + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH_TOK,
      S_CHECK_TOK,
      S_FETCH_CH,
      S_CHECK_CH,
      S_WR_SEP,
      S_WR_END,
      S_DONE,
      S_ERR
   } state_t;

   state_t                state_q, state_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] tp_q, tp_d;
   logic [ADDR_WIDTH-1:0] va_q, va_d;
   logic [ADDR_WIDTH-1:0] op_q, op_d;
   logic [LEN_W-1:0]      len_q, len_d;
`ifdef DECODER_WORD_COUNT_EN
   logic [ADDR_WIDTH-1:0] wc_q, wc_d;
`endif

   // Write port is a decode of the current state: the character being
   // written is the vocab read data, which is only valid in CHECK_CH.
   logic                  out_we;
   logic [DATA_WIDTH-1:0] out_data;

   logic op_full;
   logic len_full;

   // The last output slot is kept free for the end marker.
   assign op_full  = (op_q == '1);
   assign len_full = (len_q == LEN_W'(MAX_WORD_LEN));

   always_comb begin
      state_d  = state_q;
      done_d   = done_q;
      err_d    = err_q;
      tp_d     = tp_q;
      va_d     = va_q;
      op_d     = op_q;
      len_d    = len_q;
`ifdef DECODER_WORD_COUNT_EN
      wc_d     = wc_q;
`endif
      out_we   = 1'b0;
      out_data = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.cs) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               tp_d    = '0;
               op_d    = '0;
`ifdef DECODER_WORD_COUNT_EN
               wc_d    = '0;
`endif
               state_d = S_FETCH_TOK;
            end
         end

         S_FETCH_TOK: state_d = S_CHECK_TOK;

         S_CHECK_TOK: begin
            if (bus.tok_data == '0) begin
               state_d = S_WR_END;
            end else begin
               va_d    = ADDR_WIDTH'(bus.tok_data);
               len_d   = '0;
               state_d = S_FETCH_CH;
            end
         end

         S_FETCH_CH: state_d = S_CHECK_CH;

         S_CHECK_CH: begin
            if (bus.voc_data == '0) begin
               state_d = S_WR_SEP;
            end else if (op_full || len_full) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               out_we   = 1'b1;
               out_data = bus.voc_data;
               op_d     = op_q + 1'b1;
               // va wraps freely: the vocab is treated as circular.
               va_d     = va_q + 1'b1;
               // len_full was false, so this never passes MAX_WORD_LEN.
               len_d    = len_q + 1'b1;
               state_d  = S_FETCH_CH;
            end
         end

         S_WR_SEP: begin
            if (op_full) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               out_we = 1'b1;
               op_d   = op_q + 1'b1;
`ifdef DECODER_WORD_COUNT_EN
               wc_d   = wc_q + 1'b1;
`endif
               // Token RAM exhausted without a 0 token: close the stream.
               if (tp_q == '1) begin
                  state_d = S_WR_END;
               end else begin
                  tp_d    = tp_q + 1'b1;
                  state_d = S_FETCH_TOK;
               end
            end
         end

         S_WR_END: begin
            out_we  = 1'b1;
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = S_DONE;
         end

         S_DONE:  state_d = S_IDLE;

         S_ERR:   state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         tp_q    <= '0;
         va_q    <= '0;
         op_q    <= '0;
         len_q   <= '0;
`ifdef DECODER_WORD_COUNT_EN
         wc_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
         tp_q    <= tp_d;
         va_q    <= va_d;
         op_q    <= op_d;
         len_q   <= len_d;
`ifdef DECODER_WORD_COUNT_EN
         wc_q    <= wc_d;
`endif
      end
   end

   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.tok_addr = tp_q;
   assign bus.voc_addr = va_q;
   assign bus.out_addr = op_q;
   assign bus.out_data = out_data;
   assign bus.out_we   = out_we;
`ifdef DECODER_WORD_COUNT_EN
   assign bus.word_count = wc_q;
`endif

endmodule

// File: tb/tb_token_decoder.sv
// ---------------------------------------------------------------------------
// tb_token_decoder
//
// Drives two decoders (MAX_WORD_LEN 15 and 3) sharing token/vocab SRAM
// contents. A reference model walks the memories and pushes every expected
// output write into a per-DUT queue; a monitor pops and compares each write
// the DUT performs. Done timing, err and (optionally) word_count are
// compared against values from the same model.
// ---------------------------------------------------------------------------
module tb_token_decoder;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 2 ** AW;
   localparam int TMO   = 300;

   typedef logic [AW+DW-1:0] wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   token_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
   token_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

   token_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORD_LEN(15)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   token_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORD_LEN(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   logic [DW-1:0] tok_mem [DEPTH];
   logic [DW-1:0] voc_mem [DEPTH];

   wr_t q_a[$];
   wr_t q_b[$];

   int n_checks = 0;
   int n_pass   = 0;

   // Synchronous-read SRAM models, one read port per DUT.
   always @(posedge clk) begin
      bus_a.tok_data <= tok_mem[bus_a.tok_addr];
      bus_a.voc_data <= voc_mem[bus_a.voc_addr];
      bus_b.tok_data <= tok_mem[bus_b.tok_addr];
      bus_b.voc_data <= voc_mem[bus_b.voc_addr];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
   endtask

   // Write monitors: every DUT write must match the head of its queue.
   always @(negedge clk) begin
      if (!rst && bus_a.out_we === 1'b1) begin
         check("a_wr_expected", 32'(q_a.size() != 0), 32'd1);
         if (q_a.size() != 0)
            check("a_wr", 32'({bus_a.out_addr, bus_a.out_data}), 32'(q_a.pop_front()));
      end
      if (!rst && bus_b.out_we === 1'b1) begin
         check("b_wr_expected", 32'(q_b.size() != 0), 32'd1);
         if (q_b.size() != 0)
            check("b_wr", 32'({bus_b.out_addr, bus_b.out_data}), 32'(q_b.pop_front()));
      end
   end

   function automatic void push(input int sel, input int addr, input logic [DW-1:0] d);
      wr_t w;
      w = {AW'(addr), d};
      if (sel == 0) q_a.push_back(w);
      else          q_b.push_back(w);
   endfunction

   function automatic int q_size(input int sel);
      return (sel == 0) ? q_a.size() : q_b.size();
   endfunction

   function automatic logic get_done(input int sel);
      return (sel == 0) ? bus_a.done : bus_b.done;
   endfunction

   function automatic logic get_err(input int sel);
      return (sel == 0) ? bus_a.err : bus_b.err;
   endfunction

   task automatic drive_cs(input int sel, input logic v);
      if (sel == 0) bus_a.cs = v;
      else          bus_b.cs = v;
   endtask

   // Software reference: walk tokens, copy words, queue expected writes.
   // t = cycle (counting the accept cycle as 0) in which done is first seen.
   task automatic model(input int sel, input int max_len,
                        output bit e, output int t, output int wc);
      int op, tp, va, len;
      logic [DW-1:0] tok, ch;
      bit fin, word_end;
      op = 0; tp = 0; t = 0; e = 0; wc = 0; fin = 0;
      while (!fin) begin
         tok = tok_mem[tp];
         t += 2;
         if (tok == 0) begin
            push(sel, op, 8'h00);
            t += 1;
            fin = 1;
         end else begin
            va = int'(tok[AW-1:0]);
            len = 0;
            word_end = 0;
            while (!word_end) begin
               ch = voc_mem[va];
               t += 2;
               if (ch == 0) begin
                  word_end = 1;
               end else if (op == DEPTH - 1 || len == max_len) begin
                  e = 1; fin = 1; word_end = 1;
               end else begin
                  push(sel, op, ch);
                  op++;
                  va = (va + 1) % DEPTH;
                  len++;
               end
            end
            if (!fin) begin
               t += 1;
               if (op == DEPTH - 1) begin
                  e = 1; fin = 1;
               end else begin
                  push(sel, op, 8'h00);
                  op++;
                  wc++;
                  if (tp == DEPTH - 1) begin
                     t += 1;
                     push(sel, op, 8'h00);
                     fin = 1;
                  end else begin
                     tp++;
                  end
               end
            end
         end
      end
      t += 1;
   endtask

   task automatic wait_done(input int sel, inout int cyc);
      while (get_done(sel) !== 1'b1 && cyc < TMO) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic check_end(input int sel, input string name, input int cyc,
                            input bit e, input int t, input int wc);
      check({name, "_cycles"}, 32'(cyc), 32'(t));
      check({name, "_err"}, 32'(get_err(sel)), 32'(e));
      check({name, "_pending"}, 32'(q_size(sel)), 32'd0);
`ifdef DECODER_WORD_COUNT_EN
      check({name, "_wcount"}, 32'((sel == 0) ? bus_a.word_count : bus_b.word_count), 32'(wc));
`else
      if (wc < 0) $display("unexpected word count %0d", wc);
`endif
   endtask

   task automatic decode(input int sel, input string name);
      bit e;
      int t, wc, cyc;
      model(sel, (sel == 1) ? 3 : 15, e, t, wc);
      @(negedge clk);
      drive_cs(sel, 1'b1);
      @(negedge clk);
      drive_cs(sel, 1'b0);
      cyc = 1;
      check({name, "_done_clr"}, 32'(get_done(sel)), 32'd0);
      wait_done(sel, cyc);
      check_end(sel, name, cyc, e, t, wc);
      @(negedge clk);
      check({name, "_done_hold"}, 32'(get_done(sel)), 32'd1);
   endtask

   task automatic clear_mems();
      for (int i = 0; i < DEPTH; i++) begin
         tok_mem[i] = '0;
         voc_mem[i] = '0;
      end
   endtask

   task automatic load_normal();
      clear_mems();
      voc_mem[1] = "t"; voc_mem[2] = "h"; voc_mem[3] = "e";
      voc_mem[5] = "i"; voc_mem[6] = "s";
      tok_mem[0] = 8'd1; tok_mem[1] = 8'd5; tok_mem[2] = 8'd0;
   endtask

   initial begin
      bit e, e2;
      int t, t2, wc, wc2, cyc;

      bus_a.cs = 1'b0;
      bus_b.cs = 1'b0;
      clear_mems();
      repeat (3) @(negedge clk);

      check("rst_done",     32'(bus_a.done),     32'd0);
      check("rst_err",      32'(bus_a.err),      32'd0);
      check("rst_we",       32'(bus_a.out_we),   32'd0);
      check("rst_tok_addr", 32'(bus_a.tok_addr), 32'd0);
      check("rst_voc_addr", 32'(bus_a.voc_addr), 32'd0);
      check("rst_out_addr", 32'(bus_a.out_addr), 32'd0);
      check("rst_out_data", 32'(bus_a.out_data), 32'd0);
      check("rst_b_done",   32'(bus_b.done),     32'd0);
      rst = 1'b0;

      load_normal();
      decode(0, "normal");

      tok_mem[0] = 8'd0;
      decode(0, "empty_seq");

      tok_mem[0] = 8'd4; tok_mem[1] = 8'd0;
      decode(0, "empty_word");

      // All-ones token ID, word wraps from vocab[15] to vocab[0]=0.
      voc_mem[15] = "x"; tok_mem[0] = 8'd15; tok_mem[1] = 8'd0;
      decode(0, "tok_ones");

      // Word of length 4 against MAX_WORD_LEN=3.
      clear_mems();
      voc_mem[1] = "t"; voc_mem[2] = "h"; voc_mem[3] = "e"; voc_mem[4] = "n";
      tok_mem[0] = 8'd1;
      decode(1, "maxlen3");

      // Vocab with no terminator anywhere: output overflow stop.
      for (int i = 0; i < DEPTH; i++) voc_mem[i] = 8'(8'h41 + i);
      tok_mem[0] = 8'd1;
      decode(0, "overflow");

      // Reset during the second FETCH_CH of "the".
      load_normal();
      push(0, 0, "t");
      @(negedge clk);
      bus_a.cs = 1'b1;
      @(negedge clk);
      bus_a.cs = 1'b0;
      cyc = 1;
      while (cyc < 5) begin
         @(negedge clk);
         cyc++;
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst_done",     32'(bus_a.done),     32'd0);
      check("midrst_err",      32'(bus_a.err),      32'd0);
      check("midrst_we",       32'(bus_a.out_we),   32'd0);
      check("midrst_out_addr", 32'(bus_a.out_addr), 32'd0);
      check("midrst_pending",  32'(q_a.size()),     32'd0);
      rst = 1'b0;
      decode(0, "after_rst");

      // cs held high through DONE: a second decode starts right after.
      model(0, 15, e, t, wc);
      model(0, 15, e2, t2, wc2);
      @(negedge clk);
      bus_a.cs = 1'b1;
      @(negedge clk);
      cyc = 1;
      wait_done(0, cyc);
      check("held1_cycles", 32'(cyc), 32'(t));
      check("held1_err", 32'(bus_a.err), 32'(e));
      @(negedge clk);
      check("held_done_idle", 32'(bus_a.done), 32'd1);
      @(negedge clk);
      check("held_done_drop", 32'(bus_a.done), 32'd0);
      bus_a.cs = 1'b0;
      cyc = 1;
      wait_done(0, cyc);
      check_end(0, "held2", cyc, e2, t2, wc2);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
